// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for the UART RX path.
// It detects the start edge, tracks the oversample index and the data-bit index,
// and strobes the sampler, deserializer and start/parity/stop checkers at the
// check point of each bit. It issues a one-cycle data_valid after an error-free
// frame. It holds no data.
// Ports:
//   CLK, RST            oversampling clock, async active-low reset
//   RX_IN               serial line (idle high); synchronized upstream
//   PAR_EN, PRESCALE    frame config, latched when the start edge is seen
//   strt_glitch, par_error, stp_error   registered checker results
//   edge_cnt, bit_cnt   oversample index / data-bit index
//   dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en   datapath enables
//   data_valid          one-cycle pulse per good frame
//   busy                high outside IDLE
module uart_rx_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RX_IN,
  input  logic                        PAR_EN,
  input  logic [PRESC_WIDTH-1:0]      PRESCALE,
  input  logic                        strt_glitch,
  input  logic                        par_error,
  input  logic                        stp_error,
  output logic [PRESC_WIDTH-1:0]      edge_cnt,
  output logic [$clog2(DATA_WIDTH):0] bit_cnt,
  output logic                        dat_samp_en,
  output logic                        deser_en,
  output logic                        strt_chk_en,
  output logic                        par_chk_en,
  output logic                        stp_chk_en,
  output logic                        data_valid,
  output logic                        busy
);
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_nxt;
  logic [PRESC_WIDTH-1:0] presc_l, presc_nxt, edge_nxt, last_edge, chk_edge;
  logic [BW-1:0]          bit_nxt;
  logic                   par_en_l, par_en_nxt, par_fail, par_fail_nxt, bit_end, chk;
  logic                   samp_d, deser_d, strt_d, par_d, stp_d, dv_d, busy_d;

  // Frame timing comes from the latched prescale so mid-frame changes are ignored.
  assign last_edge = presc_l - 1'b1;
  // One past the sampler's majority window (P/2-1 .. P/2+1).
  assign chk_edge  = (presc_l >> 1) + PRESC_WIDTH'(2);
  assign bit_end   = (state != IDLE) && (edge_cnt == last_edge);

  // State register; all outputs are registered alongside it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      presc_l     <= '0;
      par_en_l    <= 1'b0;
      par_fail    <= 1'b0;
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      edge_cnt    <= edge_nxt;
      bit_cnt     <= bit_nxt;
      presc_l     <= presc_nxt;
      par_en_l    <= par_en_nxt;
      par_fail    <= par_fail_nxt;
      dat_samp_en <= samp_d;
      deser_en    <= deser_d;
      strt_chk_en <= strt_d;
      par_chk_en  <= par_d;
      stp_chk_en  <= stp_d;
      data_valid  <= dv_d;
      busy        <= busy_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt    = state;
    edge_nxt     = '0;
    bit_nxt      = bit_cnt;
    presc_nxt    = presc_l;
    par_en_nxt   = par_en_l;
    par_fail_nxt = par_fail;
    if (state != IDLE)
      edge_nxt = bit_end ? '0 : edge_cnt + 1'b1;
    case (state)
      IDLE: begin
        bit_nxt = '0;
        if (!RX_IN) begin
          state_nxt    = START;
          presc_nxt    = PRESCALE;
          par_en_nxt   = PAR_EN;
          // Stale parity result from an earlier frame must not leak in.
          par_fail_nxt = 1'b0;
        end
      end
      START: if (bit_end) begin
        bit_nxt   = '0;
        state_nxt = strt_glitch ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
          bit_nxt   = '0;
          state_nxt = par_en_l ? PARITY : STOP;
        end else begin
          bit_nxt = bit_cnt + 1'b1;
        end
      end
      // A parity error is remembered, not fatal: the stop bit is still checked.
      PARITY: if (bit_end) begin
        par_fail_nxt = par_error;
        state_nxt    = STOP;
      end
      STOP: if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: computed from next-cycle state/edge so the registered
  // strobes line up with the edge_cnt value they belong to.
  always_comb begin
    busy_d  = (state_nxt != IDLE);
    samp_d  = busy_d;
    chk     = busy_d && (edge_nxt == chk_edge);
    strt_d  = chk && (state_nxt == START);
    deser_d = chk && (state_nxt == DATA);
    par_d   = chk && (state_nxt == PARITY);
    stp_d   = chk && (state_nxt == STOP);
    dv_d    = (state == STOP) && bit_end && !stp_error && !(par_en_l && par_fail);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboarded bench for uart_rx_ctrl. The driver serializes frames on RX_IN
// and emulates the registered checkers; for each frame it pushes the expected
// frame summary (busy length, strobe counts, received byte, data_valid) worked
// out from frame rules. A monitor accumulates what the DUT does while busy and
// compares on the first idle cycle after each frame.
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0;
  logic [PW-1:0] PRESCALE = 6'd8;
  logic          strt_glitch = 1'b0, par_error = 1'b0, stp_error = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, busy;

  int errors = 0;
  int checks = 0;
  bit cfg_glitch = 0, cfg_par = 0, cfg_stp = 0;

  typedef struct {
    int         p;
    bit         pe;
    bit         glitch;
    logic [7:0] data;
    bit         dv;
    int         len;
  } exp_t;
  exp_t exp_q[$];

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PRESCALE(PRESCALE),
    .strt_glitch(strt_glitch), .par_error(par_error), .stp_error(stp_error),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Registered checker models: result appears one cycle after the strobe and holds.
  initial forever begin
    @(negedge CLK);
    if (RST && strt_chk_en) begin @(posedge CLK); #1 strt_glitch = cfg_glitch; end
  end
  initial forever begin
    @(negedge CLK);
    if (RST && par_chk_en) begin @(posedge CLK); #1 par_error = cfg_par; end
  end
  initial forever begin
    @(negedge CLK);
    if (RST && stp_chk_en) begin @(posedge CLK); #1 stp_error = cfg_stp; end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Call at #1 after a posedge. toggle: change PRESCALE/PAR_EN after the start bit.
  task automatic send_frame(input int p, input bit pe, input logic [7:0] d,
                            input bit gl, input bit perr, input bit serr, input bit toggle);
    exp_t e;
    e.p      = p;
    e.pe     = pe;
    e.glitch = gl;
    e.data   = d;
    e.len    = gl ? p : (2 + DW + int'(pe)) * p;
    e.dv     = !gl && !serr && !(pe && perr);
    exp_q.push_back(e);
    cfg_glitch = gl;
    cfg_par    = perr;
    cfg_stp    = serr;
    PRESCALE   = PW'(p);
    PAR_EN     = pe;
    RX_IN      = 1'b0;
    if (gl) begin
      hold(2);
      RX_IN = 1'b1;
      hold(p);
    end else begin
      hold(p);
      if (toggle) begin PRESCALE = PW'(16); PAR_EN = !pe; end
      for (int i = 0; i < DW; i++) begin RX_IN = d[i]; hold(p); end
      if (pe) begin RX_IN = ^d; hold(p); end
      RX_IN = 1'b1;
      hold(p);
    end
    RX_IN = 1'b1;
    hold(3);
  endtask

  task automatic reset_mid_frame();
    cfg_glitch = 0; cfg_par = 0; cfg_stp = 0;
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    hold(8);
    for (int i = 0; i < 3; i++) begin RX_IN = i[0]; hold(8); end
    RX_IN = 1'b1;
    hold(3);
    @(negedge CLK);
    chk("pre_rst_bit_cnt", bit_cnt, 3);
    chk("pre_rst_busy", busy, 1);
    RST = 1'b0;
    #1;
    chk("midframe_rst_outputs", {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                                 par_chk_en, stp_chk_en, data_valid, busy}, 0);
    hold(3);
    RST = 1'b1;
    hold(2);
  endtask

  // Monitor / scoreboard.
  initial begin
    int len, nd, np, ns, nst, mis, ce;
    logic [7:0] sh;
    bit pb;
    exp_t e;
    len = 0; nd = 0; np = 0; ns = 0; nst = 0; mis = 0; sh = '0; pb = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        len = 0; nd = 0; np = 0; ns = 0; nst = 0; mis = 0; sh = '0; pb = 0;
      end else begin
        if (busy) begin
          ce = (exp_q.size() > 0) ? exp_q[0].p / 2 + 2 : -1;
          len++;
          if (!dat_samp_en) mis++;
          if (deser_en) begin nd++; sh = {RX_IN, sh[7:1]}; end
          if (strt_chk_en) nst++;
          if (par_chk_en) np++;
          if (stp_chk_en) ns++;
          if ((deser_en || strt_chk_en || par_chk_en || stp_chk_en) && int'(edge_cnt) != ce) mis++;
          if ((int'(deser_en) + int'(strt_chk_en) + int'(par_chk_en) + int'(stp_chk_en)) > 1) mis++;
          if (data_valid) chk("dv_while_busy", 1, 0);
        end else if (pb) begin
          if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("busy_len", len, e.len);
            chk("deser_cnt", nd, e.glitch ? 0 : DW);
            chk("strt_chk_cnt", nst, 1);
            chk("par_chk_cnt", np, (!e.glitch && e.pe) ? 1 : 0);
            chk("stp_chk_cnt", ns, e.glitch ? 0 : 1);
            chk("strobe_place", mis, 0);
            chk("data_valid", data_valid, e.dv);
            if (!e.glitch) chk("rx_byte", sh, e.data);
          end
          len = 0; nd = 0; np = 0; ns = 0; nst = 0; mis = 0; sh = '0;
        end else if (data_valid) begin
          chk("stray_dv", 1, 0);
        end
        pb = busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p, wait_cnt;
    bit pe, gl, pr, se;
    repeat (2) @(negedge CLK);
    chk("reset_outputs", {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                          par_chk_en, stp_chk_en, data_valid, busy}, 0);
    @(posedge CLK); #1 RST = 1'b1;
    hold(2);

    send_frame(8,  1, 8'hA5, 0, 0, 0, 0);   // clean frame with parity
    send_frame(8,  0, 8'h00, 1, 0, 0, 0);   // false start
    send_frame(16, 1, 8'h5A, 0, 1, 0, 0);   // parity error
    par_error = 1'b1;
    send_frame(8,  0, 8'hC3, 0, 1, 0, 0);   // no parity, stale par_error high
    send_frame(8,  1, 8'h96, 0, 0, 0, 1);   // config changed mid-frame
    send_frame(16, 0, 8'h11, 0, 0, 0, 0);   // next frame uses the new prescale
    send_frame(32, 1, 8'hFF, 0, 0, 0, 0);
    send_frame(8,  0, 8'h33, 0, 0, 1, 0);   // stop error
    reset_mid_frame();
    send_frame(8,  0, 8'h3C, 0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      p  = 8 << $urandom_range(0, 2);
      pe = 1'($urandom_range(0, 1));
      gl = ($urandom_range(0, 5) == 0);
      pr = ($urandom_range(0, 3) == 0);
      se = ($urandom_range(0, 3) == 0);
      send_frame(p, pe, 8'($urandom()), gl, pr, se, 0);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 1000) begin @(posedge CLK); wait_cnt++; end
    hold(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART RX path. It detects the start edge on RX_IN and tracks the oversampling edge and bit position within the frame. It strobes the enables for the sampler, the deserializer and the start/parity/stop checkers. After the stop bit it issues a one-cycle data_valid only when the frame had no detected error. It sits between the RX line and the RX datapath blocks, which it sequences; it holds no data itself.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESC_WIDTH, 6, width of PRESCALE and edge_cnt

Ports:
CLK  in  1  RX oversampling clock
RST  in  1  asynchronous reset, active-low
RX_IN  in  1  serial line, idle high
PAR_EN  in  1  1 = frame carries a parity bit
PRESCALE  in  PRESC_WIDTH  oversampling ratio; legal values are even and >= 8 (8/16/32 supported)
strt_glitch  in  1  start checker result, registered; valid 1 cycle after strt_chk_en
par_error  in  1  parity checker result, registered; valid 1 cycle after par_chk_en
stp_error  in  1  stop checker result, registered; valid 1 cycle after stp_chk_en
edge_cnt  out  PRESC_WIDTH  oversample index within current bit
bit_cnt  out  $clog2(DATA_WIDTH)+1  data-bit index
dat_samp_en  out  1  sampler enable
deser_en  out  1  one-cycle strobe: shift sampled bit into deserializer
strt_chk_en  out  1  one-cycle strobe
par_chk_en  out  1  one-cycle strobe
stp_chk_en  out  1  one-cycle strobe
data_valid  out  1  one-cycle pulse: frame received error-free
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (RST low, async): state=IDLE; all outputs and counters 0. Reset mid-frame abandons the frame; no data_valid is issued.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - edge_cnt and bit_cnt are held at 0.
  - RX_IN==0 sampled -> START next cycle. PRESCALE and PAR_EN are latched into internal registers on this transition; later changes to them have no effect until the next frame.
- Non-IDLE:
  - edge_cnt increments every cycle and wraps at P-1 -> 0, where P = latched PRESCALE.
  - The cycle with edge_cnt==P-1 is the "bit end"; every state transition happens on a bit end.
  - dat_samp_en=1 and busy=1.
- Check point: the cycle with edge_cnt==P/2+2, after the sampler's majority window of P/2-1..P/2+1. In that cycle exactly one strobe is high, selected by state:
  - START -> strt_chk_en
  - DATA -> deser_en
  - PARITY -> par_chk_en
  - STOP -> stp_chk_en
- Checker flags are read only at bit end. P>=8 guarantees P/2+3 <= P-1, so the flags are settled by then.
- Transitions at bit end:
  - START: strt_glitch=1 -> IDLE (false start, nothing else strobed); strt_glitch=0 -> DATA with bit_cnt=0.
  - DATA: bit_cnt increments; when bit_cnt==DATA_WIDTH-1 -> PARITY if latched PAR_EN, else STOP. bit_cnt returns to 0 on leaving DATA.
  - PARITY: the par_error value is captured into an internal par_fail flag -> STOP. The frame is not aborted on a parity error.
  - STOP: -> IDLE. data_valid=1 in the next cycle (exactly one cycle) iff stp_error==0 and (par_fail==0 or PAR_EN latched 0).
- par_fail clears on entry to START. A stale par_error from an earlier frame must not affect a no-parity frame.
- Back-to-back frames: the IDLE cycle after STOP samples RX_IN; a 0 there starts the next frame. At most one cycle of slack is lost per frame.
- Frame length from START entry to IDLE: (1 + DATA_WIDTH + PAR_EN + 1) * P cycles.
- RX_IN is not synchronized here; the upstream sampler or synchronizer owns metastability.

Test Plan:
- P=8, PAR_EN=1, byte 0xA5, even parity, checkers report no error -> 88 busy cycles; 8 deser_en strobes each at edge_cnt=6; par_chk_en and stp_chk_en once each; data_valid high for exactly 1 cycle after STOP.
- P=8, RX_IN low for 2 cycles only, strt_glitch=1 after strt_chk_en -> return to IDLE at edge_cnt=7 of START; no deser_en; no data_valid.
- P=16, PAR_EN=1, par_error=1 after par_chk_en -> STOP still traversed; stp_chk_en pulses; data_valid stays 0.
- P=8, PAR_EN=0, par_error stuck 1, stp_error=0 -> no PARITY state; 80-cycle frame; data_valid=1.
- PRESCALE changed 8->16 and PAR_EN toggled mid-frame -> current frame completes with P=8 and its original PAR_EN; the next frame uses 16.
- RST driven low during DATA at bit_cnt=3 -> all outputs 0 immediately; after release, a fresh 0x3C frame is received correctly with data_valid=1.
